// File: rtl/priority_encoder_pkg.sv
// priority_encoder_pkg: width helpers shared by the priority encoder tree and its top level.
package priority_encoder_pkg;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int enc_width(input int w);
    return (clog2(w) < 1) ? 1 : clog2(w);
  endfunction

  // Request vectors are zero-padded up to this width so the merge tree is a full binary tree.
  function automatic int pad_width(input int w);
    return 1 << enc_width(w);
  endfunction

endpackage

// File: rtl/priority_encoder_node.sv
// priority_encoder_node: merges two child (valid, index) results into one, adding index bit LVL.
module priority_encoder_node #(
  parameter int EW = 1,
  parameter int LVL = 0,
  parameter bit LSB_HIGH_PRIORITY = 1'b0
) (
  input  logic          valid_lo_i,
  input  logic [EW-1:0] enc_lo_i,
  input  logic          valid_hi_i,
  input  logic [EW-1:0] enc_hi_i,
  output logic          valid_o,
  output logic [EW-1:0] enc_o
);
  logic sel;
  // An invalid child always carries index 0, so the empty case falls out as 0 with no extra gating.
  assign sel = LSB_HIGH_PRIORITY ? (!valid_lo_i && valid_hi_i) : valid_hi_i;
  assign valid_o = valid_lo_i || valid_hi_i;
  assign enc_o = (sel ? enc_hi_i : enc_lo_i) | (EW'(sel) << LVL);
endmodule

// File: rtl/priority_encoder_reg.sv
// priority_encoder_reg: tree priority encoder (index, one-hot, valid); defining
// PRIORITY_ENCODER_REG_OUT_EN adds a 1-cycle output register with synchronous reset.
module priority_encoder_reg
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter bit LSB_HIGH_PRIORITY = 1'b0,
  localparam int ENC_WIDTH = enc_width(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     input_unencoded,
  output logic                 output_valid,
  output logic [ENC_WIDTH-1:0] output_encoded,
  output logic [WIDTH-1:0]     output_unencoded
);
  localparam int PW = pad_width(WIDTH);
  logic [PW-1:0] pad;
  logic valid_d;
  logic [ENC_WIDTH-1:0] enc_d;
  logic [WIDTH-1:0] oh_d;
  assign pad = PW'(input_unencoded);
  for (genvar l = 0; l < ENC_WIDTH; l++) begin : g_lvl
    logic [(PW>>(l+1))-1:0] v;
    logic [ENC_WIDTH-1:0] e [PW>>(l+1)];
    for (genvar n = 0; n < (PW >> (l + 1)); n++) begin : g_node
      logic vl, vh;
      logic [ENC_WIDTH-1:0] el, eh;
      if (l == 0) begin : g_in
        assign vl = pad[2*n];
        assign vh = pad[2*n+1];
        assign el = '0;
        assign eh = '0;
      end else begin : g_in
        assign vl = g_lvl[l-1].v[2*n];
        assign vh = g_lvl[l-1].v[2*n+1];
        assign el = g_lvl[l-1].e[2*n];
        assign eh = g_lvl[l-1].e[2*n+1];
      end
      priority_encoder_node #(
        .EW(ENC_WIDTH),
        .LVL(l),
        .LSB_HIGH_PRIORITY(LSB_HIGH_PRIORITY)
      ) u_node (
        .valid_lo_i(vl),
        .enc_lo_i(el),
        .valid_hi_i(vh),
        .enc_hi_i(eh),
        .valid_o(v[n]),
        .enc_o(e[n])
      );
    end
  end
  assign valid_d = g_lvl[ENC_WIDTH-1].v[0];
  assign enc_d = g_lvl[ENC_WIDTH-1].e[0];
  always_comb begin
    oh_d = '0;
    for (int i = 0; i < WIDTH; i++) oh_d[i] = valid_d && (enc_d == ENC_WIDTH'(i));
  end
`ifdef PRIORITY_ENCODER_REG_OUT_EN
  logic valid_q;
  logic [ENC_WIDTH-1:0] enc_q;
  logic [WIDTH-1:0] oh_q;
  always_ff @(posedge clk) begin
    valid_q <= rst ? 1'b0 : valid_d;
    enc_q <= rst ? '0 : enc_d;
    oh_q <= rst ? '0 : oh_d;
  end
  assign output_valid = valid_q;
  assign output_encoded = enc_q;
  assign output_unencoded = oh_q;
`else
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;
  assign output_valid = valid_d;
  assign output_encoded = enc_d;
  assign output_unencoded = oh_d;
`endif
endmodule

// File: tb/tb_priority_encoder_reg.sv
// tb_priority_encoder_reg: directed-vector bench for priority_encoder_reg in both builds
// (PRIORITY_ENCODER_REG_OUT_EN selects the registered-output checks).
module tb_priority_encoder_reg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0] in8 = '0;
  logic [69:0] in70 = '0;
  logic [4:0] in5 = '0;
  logic in1 = 1'b0;

  logic v8m, v8l, v70m, v70l, v5m, v5l, v1;
  logic [2:0] e8m, e8l, e5m, e5l;
  logic [6:0] e70m, e70l;
  logic [0:0] e1;
  logic [7:0] o8m, o8l;
  logic [69:0] o70m, o70l;
  logic [4:0] o5m, o5l;
  logic [0:0] o1;

  priority_encoder_reg #(.WIDTH(8), .LSB_HIGH_PRIORITY(1'b0)) u8m (.clk(clk), .rst(rst), .input_unencoded(in8), .output_valid(v8m), .output_encoded(e8m), .output_unencoded(o8m));
  priority_encoder_reg #(.WIDTH(8), .LSB_HIGH_PRIORITY(1'b1)) u8l (.clk(clk), .rst(rst), .input_unencoded(in8), .output_valid(v8l), .output_encoded(e8l), .output_unencoded(o8l));
  priority_encoder_reg #(.WIDTH(70), .LSB_HIGH_PRIORITY(1'b0)) u70m (.clk(clk), .rst(rst), .input_unencoded(in70), .output_valid(v70m), .output_encoded(e70m), .output_unencoded(o70m));
  priority_encoder_reg #(.WIDTH(70), .LSB_HIGH_PRIORITY(1'b1)) u70l (.clk(clk), .rst(rst), .input_unencoded(in70), .output_valid(v70l), .output_encoded(e70l), .output_unencoded(o70l));
  priority_encoder_reg #(.WIDTH(5), .LSB_HIGH_PRIORITY(1'b0)) u5m (.clk(clk), .rst(rst), .input_unencoded(in5), .output_valid(v5m), .output_encoded(e5m), .output_unencoded(o5m));
  priority_encoder_reg #(.WIDTH(5), .LSB_HIGH_PRIORITY(1'b1)) u5l (.clk(clk), .rst(rst), .input_unencoded(in5), .output_valid(v5l), .output_encoded(e5l), .output_unencoded(o5l));
  priority_encoder_reg #(.WIDTH(1), .LSB_HIGH_PRIORITY(1'b0)) u1 (.clk(clk), .rst(rst), .input_unencoded(in1), .output_valid(v1), .output_encoded(e1), .output_unencoded(o1));

  typedef struct {
    logic [7:0] in;
    logic v;
    logic [2:0] em;
    logic [2:0] el;
  } v8_t;
  typedef struct {
    logic [69:0] in;
    logic v;
    logic [6:0] em;
    logic [6:0] el;
  } v70_t;

  v8_t t8[8];
  v70_t t70[6];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic settle();
`ifdef PRIORITY_ENCODER_REG_OUT_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
  endtask

  function automatic int model(input logic [4:0] x, input bit lsb);
    int idx;
    idx = -1;
    for (int i = 0; i < 5; i++)
      if (x[i] && (!lsb || idx < 0)) idx = i;
    return idx;
  endfunction

  initial begin
    t8[0] = '{8'b0010_0110, 1'b1, 3'd5, 3'd1};
    t8[1] = '{8'h00, 1'b0, 3'd0, 3'd0};
    t8[2] = '{8'hFF, 1'b1, 3'd7, 3'd0};
    t8[3] = '{8'h80, 1'b1, 3'd7, 3'd7};
    t8[4] = '{8'h01, 1'b1, 3'd0, 3'd0};
    t8[5] = '{8'b0101_0000, 1'b1, 3'd6, 3'd4};
    t8[6] = '{8'h18, 1'b1, 3'd4, 3'd3};
    t8[7] = '{8'b1000_0001, 1'b1, 3'd7, 3'd0};
    t70[0] = '{70'd1 << 69, 1'b1, 7'd69, 7'd69};
    t70[1] = '{{70{1'b1}}, 1'b1, 7'd69, 7'd0};
    t70[2] = '{70'd1, 1'b1, 7'd0, 7'd0};
    t70[3] = '{70'd0, 1'b0, 7'd0, 7'd0};
    t70[4] = '{(70'd1 << 64) | 70'd8, 1'b1, 7'd64, 7'd3};
    t70[5] = '{70'd1 << 63, 1'b1, 7'd63, 7'd63};

`ifdef PRIORITY_ENCODER_REG_OUT_EN
    in8 = 8'hFF;
    in70 = {70{1'b1}};
    in5 = 5'h1F;
    in1 = 1'b1;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid8", 70'(v8m), 70'd0);
    chk("reset_enc8", 70'(e8m), 70'd0);
    chk("reset_oh8", 70'(o8m), 70'd0);
    chk("reset_oh70", o70m, 70'd0);
    chk("reset_valid1", 70'(v1), 70'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      in8 = t8[i].in;
      settle();
      chk($sformatf("w8_msb_valid[%0d]", i), 70'(v8m), 70'(t8[i].v));
      chk($sformatf("w8_msb_enc[%0d]", i), 70'(e8m), 70'(t8[i].em));
      chk($sformatf("w8_msb_oh[%0d]", i), 70'(o8m), t8[i].v ? (70'd1 << t8[i].em) : 70'd0);
      chk($sformatf("w8_lsb_valid[%0d]", i), 70'(v8l), 70'(t8[i].v));
      chk($sformatf("w8_lsb_enc[%0d]", i), 70'(e8l), 70'(t8[i].el));
      chk($sformatf("w8_lsb_oh[%0d]", i), 70'(o8l), t8[i].v ? (70'd1 << t8[i].el) : 70'd0);
    end

    for (int i = 0; i < 6; i++) begin
      in70 = t70[i].in;
      settle();
      chk($sformatf("w70_msb_valid[%0d]", i), 70'(v70m), 70'(t70[i].v));
      chk($sformatf("w70_msb_enc[%0d]", i), 70'(e70m), 70'(t70[i].em));
      chk($sformatf("w70_msb_oh[%0d]", i), o70m, t70[i].v ? (70'd1 << t70[i].em) : 70'd0);
      chk($sformatf("w70_lsb_valid[%0d]", i), 70'(v70l), 70'(t70[i].v));
      chk($sformatf("w70_lsb_enc[%0d]", i), 70'(e70l), 70'(t70[i].el));
      chk($sformatf("w70_lsb_oh[%0d]", i), o70l, t70[i].v ? (70'd1 << t70[i].el) : 70'd0);
    end

    for (int x = 0; x < 32; x++) begin
      int im, il;
      in5 = 5'(x);
      im = model(5'(x), 1'b0);
      il = model(5'(x), 1'b1);
      settle();
      chk($sformatf("w5_msb_valid[%0d]", x), 70'(v5m), 70'(im >= 0));
      chk($sformatf("w5_msb_enc[%0d]", x), 70'(e5m), im >= 0 ? 70'(im) : 70'd0);
      chk($sformatf("w5_msb_oh[%0d]", x), 70'(o5m), im >= 0 ? (70'd1 << im) : 70'd0);
      chk($sformatf("w5_lsb_valid[%0d]", x), 70'(v5l), 70'(il >= 0));
      chk($sformatf("w5_lsb_enc[%0d]", x), 70'(e5l), il >= 0 ? 70'(il) : 70'd0);
      chk($sformatf("w5_lsb_oh[%0d]", x), 70'(o5l), il >= 0 ? (70'd1 << il) : 70'd0);
    end

    for (int b = 0; b < 2; b++) begin
      in1 = b[0];
      settle();
      chk($sformatf("w1_valid[%0d]", b), 70'(v1), 70'(b));
      chk($sformatf("w1_enc[%0d]", b), 70'(e1), 70'd0);
      chk($sformatf("w1_oh[%0d]", b), 70'(o1), 70'(b));
    end

`ifdef PRIORITY_ENCODER_REG_OUT_EN
    @(posedge clk);
    #1;
    in8 = 8'h80;
    @(posedge clk);
    #1;
    in8 = 8'h01;
    chk("seq_enc_7", 70'(e8m), 70'd7);
    chk("seq_valid_7", 70'(v8m), 70'd1);
    @(posedge clk);
    #1;
    in8 = 8'h00;
    chk("seq_enc_0", 70'(e8m), 70'd0);
    chk("seq_valid_0", 70'(v8m), 70'd1);
    chk("seq_oh_0", 70'(o8m), 70'd1);
    @(posedge clk);
    #1;
    chk("seq_empty_valid", 70'(v8m), 70'd0);
    in8 = 8'h80;
    @(posedge clk);
    #1;
    chk("seq_reload_enc", 70'(e8m), 70'd7);
    in8 = 8'h01;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", 70'(v8m), 70'd0);
    chk("midrst_enc", 70'(e8m), 70'd0);
    chk("midrst_oh", 70'(o8m), 70'd0);
    rst = 1'b0;
    in8 = 8'h40;
    @(posedge clk);
    #1;
    chk("postrst_enc", 70'(e8m), 70'd6);
    chk("postrst_oh", 70'(o8m), 70'h40);
`else
    in8 = 8'h24;
    #1;
    repeat (3) @(posedge clk);
    #1;
    chk("comb_hold_enc", 70'(e8m), 70'd5);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("comb_rst_ignored_valid", 70'(v8m), 70'd1);
    chk("comb_rst_ignored_enc", 70'(e8l), 70'd2);
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
